// File: rtl/hwag_spi_regfile_if.sv
// SPI-side byte interface between spi_slave (master modport) and the hwag
// settings stage (slave modport).
// Strobe semantics: rx_stb is a 1-cycle valid for rx_byte/rx_crc and is never
// back-pressured; tx_byte is always valid and tx_stb is a 1-cycle "consumed" pulse.
interface hwag_spi_regfile_if;
  logic       spi_ss;
  logic       rx_stb;
  logic [7:0] rx_byte;
  logic [7:0] rx_crc;
  logic       tx_stb;
  logic [7:0] tx_byte;

  modport master (
    output spi_ss, rx_stb, rx_byte, rx_crc, tx_stb,
    input  tx_byte
  );

  modport slave (
    input  spi_ss, rx_stb, rx_byte, rx_crc, tx_stb,
    output tx_byte
  );
endinterface

// File: rtl/hwag_spi_regfile.sv
// Frame assembler, CRC/command checker and settings register file for the hwag
// core; staged settings reach cfg_* only when the core reports a safe point.
module hwag_spi_regfile #(
  parameter int          FRAME_LEN = 7,
  parameter logic [31:0] ID_VALUE  = 32'h48574147
) (
  input  logic                     clk,
  input  logic                     rst,
  hwag_spi_regfile_if.slave        spi,
  input  logic                     apply_ena,
  output logic                     cfg_enable,
  output logic [3:0]               cfg_stwd,
  output logic [23:0]              cfg_maxacr,
  output logic [18:0]              cfg_filt_nogap,
  output logic [18:0]              cfg_filt_gap,
  output logic [23:0]              cfg_dwell,
  output logic                     cfg_update,
  output logic                     frame_ok,
  output logic                     frame_err,
  output logic [7:0]               crc_err_cnt,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK, S_EXEC} state_t;

  typedef struct packed {
    logic        enable;
    logic [3:0]  stwd;
    logic [23:0] maxacr;
    logic [18:0] filt_nogap;
    logic [18:0] filt_gap;
    logic [23:0] dwell;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    enable:     1'b0,
    stwd:       4'd4,
    maxacr:     24'd3839,
    filt_nogap: 19'd45,
    filt_gap:   19'd134,
    dwell:      24'd50000
  };

  localparam int         BUF_W   = FRAME_LEN * 8;
  localparam logic [7:0] CMD_WR  = 8'h01;
  localparam logic [7:0] CMD_RD  = 8'h02;
  localparam logic [7:0] ST_OK   = 8'h00;
  localparam logic [7:0] ST_CRC  = 8'h01;
  localparam logic [7:0] ST_LEN  = 8'h02;
  localparam logic [7:0] ST_CMD  = 8'h03;
  localparam logic [7:0] ST_ADDR = 8'h04;

  state_t           state_q, state_d;
  logic             ss_q, ss_d;
  logic [3:0]       count_q, count_d;
  logic [BUF_W-1:0] rx_buf_q, rx_buf_d;
  logic [7:0]       crc_lat_q, crc_lat_d;
  logic             fall_seen_q, fall_seen_d;
  logic [7:0]       ex_cmd_q, ex_cmd_d;
  logic [7:0]       ex_addr_q, ex_addr_d;
  logic [31:0]      ex_data_q, ex_data_d;
  logic [7:0]       status_q, status_d;
  logic [7:0]       last_status_q, last_status_d;
  logic [7:0]       crc_cnt_q, crc_cnt_d;
  logic [BUF_W-1:0] resp_q, resp_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic             pending_q, pending_d;
  cfg_t             stg_q, stg_d;
  cfg_t             cfg_q, cfg_d;

  logic             ss_fall, ss_rise, rx_active, apply_now;
  logic [7:0]       chk_cmd, chk_addr, chk_status;
  logic [31:0]      rdata;
  logic [BUF_W-9:0] resp_body;

  // CRC-8, poly 0x07, init 0, over the payload bytes in transmit order.
  function automatic logic [7:0] crc8_payload(input logic [BUF_W-9:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < FRAME_LEN - 1; i++) begin
      c = c ^ d[i*8 +: 8];
      for (int b = 0; b < 8; b++) begin
        c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] read_reg(input logic [7:0] a, input cfg_t c,
                                           input logic [7:0] ecnt, input logic [7:0] lst);
    logic [31:0] r;
    case (a)
      8'h00:   r = ID_VALUE;
      8'h01:   r = {31'd0, c.enable};
      8'h02:   r = {28'd0, c.stwd};
      8'h03:   r = {8'd0, c.maxacr};
      8'h04:   r = {13'd0, c.filt_nogap};
      8'h05:   r = {13'd0, c.filt_gap};
      8'h06:   r = {8'd0, c.dwell};
      8'h07:   r = {16'd0, ecnt, lst};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign ss_fall   = ss_q & ~spi.spi_ss;
  assign ss_rise   = ~ss_q & spi.spi_ss;
  assign apply_now = pending_q & apply_ena;
  // Bytes of a following frame may arrive while the previous one still executes.
  assign rx_active = (state_q == S_RECV) ||
                     (((state_q == S_CHECK) || (state_q == S_EXEC)) && fall_seen_q);

  assign chk_cmd  = rx_buf_q[7:0];
  assign chk_addr = rx_buf_q[15:8];

  always_comb begin
    chk_status = ST_OK;
    if (count_q != 4'(FRAME_LEN)) begin
      chk_status = ST_LEN;
    end else if (rx_buf_q[(FRAME_LEN-1)*8 +: 8] != crc_lat_q) begin
      chk_status = ST_CRC;
    end else if ((chk_cmd != CMD_WR) && (chk_cmd != CMD_RD)) begin
      chk_status = ST_CMD;
    end else if ((chk_addr > 8'h07) ||
                 ((chk_cmd == CMD_WR) && ((chk_addr == 8'h00) || (chk_addr == 8'h07)))) begin
      chk_status = ST_ADDR;
    end
  end

  always_comb begin
    rdata = '0;
    if (status_q == ST_OK) begin
      rdata = (ex_cmd_q == CMD_RD) ? read_reg(ex_addr_q, cfg_q, crc_cnt_q, last_status_q)
                                   : ex_data_q;
    end
    resp_body = {rdata, ex_addr_q, status_q};
  end

  always_comb begin
    state_d       = state_q;
    ss_d          = spi.spi_ss;
    count_d       = count_q;
    rx_buf_d      = rx_buf_q;
    crc_lat_d     = crc_lat_q;
    fall_seen_d   = fall_seen_q;
    ex_cmd_d      = ex_cmd_q;
    ex_addr_d     = ex_addr_q;
    ex_data_d     = ex_data_q;
    status_d      = status_q;
    last_status_d = last_status_q;
    crc_cnt_d     = crc_cnt_q;
    resp_d        = resp_q;
    tx_idx_d      = tx_idx_q;
    pending_d     = pending_q;
    stg_d         = stg_q;
    cfg_d         = cfg_q;
    frame_ok      = 1'b0;
    frame_err     = 1'b0;

    if (ss_fall) begin
      count_d   = '0;
      rx_buf_d  = '0;
      crc_lat_d = '0;
      tx_idx_d  = '0;
    end else begin
      if (spi.tx_stb && (tx_idx_q != 3'(FRAME_LEN - 1))) tx_idx_d = tx_idx_q + 3'd1;
      if (rx_active && spi.rx_stb) begin
        for (int k = 0; k < FRAME_LEN; k++) begin
          if (count_q == 4'(k)) rx_buf_d[k*8 +: 8] = spi.rx_byte;
        end
        if (count_q == 4'(FRAME_LEN - 2)) crc_lat_d = spi.rx_crc;
        if (count_q != 4'd8) count_d = count_q + 4'd1;
      end
    end

    if (apply_now) begin
      cfg_d     = stg_q;
      pending_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (ss_fall) state_d = S_RECV;
      end
      S_RECV: begin
        fall_seen_d = 1'b0;
        if (ss_rise) state_d = (count_d == 4'd0) ? S_IDLE : S_CHECK;
      end
      S_CHECK: begin
        ex_cmd_d  = chk_cmd;
        ex_addr_d = chk_addr;
        ex_data_d = rx_buf_q[16 +: 32];
        status_d  = chk_status;
        if (ss_fall) fall_seen_d = 1'b0 | 1'b1;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        frame_ok      = (status_q == ST_OK);
        frame_err     = (status_q != ST_OK);
        last_status_d = status_q;
        resp_d        = {crc8_payload(resp_body), resp_body};
        if ((status_q == ST_CRC) && (crc_cnt_q != 8'hFF)) crc_cnt_d = crc_cnt_q + 8'd1;
        // A write landing on an apply edge stays pending for the next safe point.
        if ((status_q == ST_OK) && (ex_cmd_q == CMD_WR)) begin
          pending_d = 1'b1;
          case (ex_addr_q)
            8'h01:   stg_d.enable     = ex_data_q[0];
            8'h02:   stg_d.stwd       = ex_data_q[3:0];
            8'h03:   stg_d.maxacr     = ex_data_q[23:0];
            8'h04:   stg_d.filt_nogap = ex_data_q[18:0];
            8'h05:   stg_d.filt_gap   = ex_data_q[18:0];
            8'h06:   stg_d.dwell      = ex_data_q[23:0];
            default: pending_d        = pending_d;
          endcase
        end
        fall_seen_d = 1'b0;
        if (fall_seen_q || ss_fall) begin
          if (spi.spi_ss && !ss_fall) state_d = (count_d == 4'd0) ? S_IDLE : S_CHECK;
          else                        state_d = S_RECV;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ss_q          <= 1'b1;
      count_q       <= '0;
      rx_buf_q      <= '0;
      crc_lat_q     <= '0;
      fall_seen_q   <= 1'b0;
      ex_cmd_q      <= '0;
      ex_addr_q     <= '0;
      ex_data_q     <= '0;
      status_q      <= '0;
      last_status_q <= '0;
      crc_cnt_q     <= '0;
      resp_q        <= '0;
      tx_idx_q      <= '0;
      pending_q     <= 1'b0;
      stg_q         <= CFG_RESET;
      cfg_q         <= CFG_RESET;
    end else begin
      state_q       <= state_d;
      ss_q          <= ss_d;
      count_q       <= count_d;
      rx_buf_q      <= rx_buf_d;
      crc_lat_q     <= crc_lat_d;
      fall_seen_q   <= fall_seen_d;
      ex_cmd_q      <= ex_cmd_d;
      ex_addr_q     <= ex_addr_d;
      ex_data_q     <= ex_data_d;
      status_q      <= status_d;
      last_status_q <= last_status_d;
      crc_cnt_q     <= crc_cnt_d;
      resp_q        <= resp_d;
      tx_idx_q      <= tx_idx_d;
      pending_q     <= pending_d;
      stg_q         <= stg_d;
      cfg_q         <= cfg_d;
    end
  end

  assign spi.tx_byte     = resp_q[{tx_idx_q, 3'b000} +: 8];
  assign cfg_enable      = cfg_q.enable;
  assign cfg_stwd        = cfg_q.stwd;
  assign cfg_maxacr      = cfg_q.maxacr;
  assign cfg_filt_nogap  = cfg_q.filt_nogap;
  assign cfg_filt_gap    = cfg_q.filt_gap;
  assign cfg_dwell       = cfg_q.dwell;
  assign cfg_update      = apply_now;
  assign crc_err_cnt     = crc_cnt_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_hwag_spi_regfile.sv
// Randomized frame traffic against a register-level model of the settings
// block: status rules, staging/apply, response frame and tx byte stream.
module tb_hwag_spi_regfile;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        apply_ena = 1'b0;
  logic        cfg_enable, cfg_update, frame_ok, frame_err;
  logic [3:0]  cfg_stwd;
  logic [23:0] cfg_maxacr, cfg_dwell;
  logic [18:0] cfg_filt_nogap, cfg_filt_gap;
  logic [7:0]  crc_err_cnt;
  logic [1:0]  dbg_state;

  hwag_spi_regfile_if spi();

  hwag_spi_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .spi            (spi),
    .apply_ena      (apply_ena),
    .cfg_enable     (cfg_enable),
    .cfg_stwd       (cfg_stwd),
    .cfg_maxacr     (cfg_maxacr),
    .cfg_filt_nogap (cfg_filt_nogap),
    .cfg_filt_gap   (cfg_filt_gap),
    .cfg_dwell      (cfg_dwell),
    .cfg_update     (cfg_update),
    .frame_ok       (frame_ok),
    .frame_err      (frame_err),
    .crc_err_cnt    (crc_err_cnt),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // pulse monitor
  int cyc = 0, ok_cnt = 0, err_cnt = 0, upd_cnt = 0, ok_cyc = 0, upd_cyc = 0;
  always @(negedge clk) begin
    cyc++;
    if (rst && frame_ok)   begin ok_cnt++;  ok_cyc = cyc;  end
    if (rst && frame_err)  err_cnt++;
    if (rst && cfg_update) begin upd_cnt++; upd_cyc = cyc; end
  end

  // reference model: registers indexed by address
  logic [31:0] m_cfg[8];
  logic [31:0] m_stg[8];
  bit          m_pending;
  int          m_crc_cnt;
  logic [7:0]  m_last_status;
  logic [7:0]  m_resp[7];

  function automatic logic [31:0] wmask(input int a);
    case (a)
      1: return 32'h1;
      2: return 32'hF;
      3: return 32'hFF_FFFF;
      4: return 32'h7_FFFF;
      5: return 32'h7_FFFF;
      6: return 32'hFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int b = 0; b < 8; b++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  task automatic model_reset();
    m_cfg[0] = 0; m_cfg[1] = 0; m_cfg[2] = 4; m_cfg[3] = 3839;
    m_cfg[4] = 45; m_cfg[5] = 134; m_cfg[6] = 50000; m_cfg[7] = 0;
    for (int i = 0; i < 8; i++) m_stg[i] = m_cfg[i];
    m_pending = 0; m_crc_cnt = 0; m_last_status = 0;
    for (int i = 0; i < 7; i++) m_resp[i] = 8'h00;
  endtask

  task automatic check_cfg(input string tag);
    check({tag, "_en"},    {31'd0, cfg_enable}, m_cfg[1] & 32'h1);
    check({tag, "_stwd"},  {28'd0, cfg_stwd}, m_cfg[2]);
    check({tag, "_macr"},  {8'd0, cfg_maxacr}, m_cfg[3]);
    check({tag, "_fng"},   {13'd0, cfg_filt_nogap}, m_cfg[4]);
    check({tag, "_fg"},    {13'd0, cfg_filt_gap}, m_cfg[5]);
    check({tag, "_dwell"}, {8'd0, cfg_dwell}, m_cfg[6]);
    check({tag, "_crccnt"}, {24'd0, crc_err_cnt}, m_crc_cnt);
  endtask

  function automatic bq_t mk_frame(input logic [7:0] cmd, input logic [7:0] addr,
                                   input logic [31:0] data, input bit corrupt);
    bq_t q;
    logic [7:0] c;
    q = {cmd, addr, data[7:0], data[15:8], data[23:16], data[31:24]};
    c = 0;
    foreach (q[i]) c = crc_step(c, q[i]);
    q.push_back(corrupt ? (c ^ 8'h5A) : c);
    return q;
  endfunction

  // driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input string tag, input bq_t b, input bit apply_on);
    logic [7:0]  prev[7];
    logic [7:0]  c, st, addr;
    logic [31:0] data;
    int          n, ok0, err0, upd0;
    bit          good;
    n = b.size();
    prev = m_resp;
    ok0 = ok_cnt; err0 = err_cnt; upd0 = upd_cnt;
    c = 0;
    spi.spi_ss = 1'b0;
    tick(); tick();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_tx%0d", tag, i), {24'd0, spi.tx_byte}, {24'd0, prev[(i > 6) ? 6 : i]});
      c = crc_step(c, b[i]);
      spi.rx_byte = b[i]; spi.rx_crc = c;
      spi.rx_stb = 1'b1; spi.tx_stb = 1'b1;
      tick();
      spi.rx_stb = 1'b0; spi.tx_stb = 1'b0;
      tick(); tick();
    end
    spi.spi_ss = 1'b1;
    repeat (8) tick();

    if (n == 0) begin
      check({tag, "_ok_none"}, ok_cnt - ok0, 0);
      check({tag, "_err_none"}, err_cnt - err0, 0);
    end else begin
      c = 0;
      for (int i = 0; i < 6 && i < n; i++) c = crc_step(c, b[i]);
      if (n != 7)                                  st = 8'h02;
      else if (b[6] != c)                          st = 8'h01;
      else if (b[0] != 8'h01 && b[0] != 8'h02)     st = 8'h03;
      else if (b[1] > 7 || (b[0] == 8'h01 && (b[1] == 0 || b[1] == 7))) st = 8'h04;
      else                                         st = 8'h00;
      good = (st == 8'h00);
      addr = (n >= 2) ? b[1] : 8'h00;
      data = 0;
      if (good && b[0] == 8'h01) begin
        data = {b[5], b[4], b[3], b[2]};
        m_stg[b[1]] = data & wmask(b[1]);
        m_pending = 1;
      end else if (good) begin
        if (b[1] == 0)      data = 32'h48574147;
        else if (b[1] == 7) data = {16'd0, 8'(m_crc_cnt), m_last_status};
        else                data = m_cfg[b[1]];
      end
      if (st == 8'h01 && m_crc_cnt < 255) m_crc_cnt++;
      m_last_status = st;
      m_resp[0] = st; m_resp[1] = addr;
      for (int i = 0; i < 4; i++) m_resp[2+i] = data[i*8 +: 8];
      c = 0;
      for (int i = 0; i < 6; i++) c = crc_step(c, m_resp[i]);
      m_resp[6] = c;
      check({tag, "_ok"}, ok_cnt - ok0, good ? 1 : 0);
      check({tag, "_err"}, err_cnt - err0, good ? 0 : 1);
    end
    if (apply_on && m_pending) begin
      for (int i = 0; i < 8; i++) m_cfg[i] = m_stg[i];
      m_pending = 0;
      check({tag, "_upd"}, upd_cnt - upd0, 1);
    end else begin
      check({tag, "_noupd"}, upd_cnt - upd0, 0);
    end
    check_cfg(tag);
  endtask

  task automatic apply_pulse(input string tag);
    int u0;
    bit had;
    u0 = upd_cnt;
    had = m_pending;
    apply_ena = 1'b1;
    tick();
    apply_ena = 1'b0;
    tick();
    check({tag, "_updcnt"}, upd_cnt - u0, had ? 1 : 0);
    if (had) begin
      for (int i = 0; i < 8; i++) m_cfg[i] = m_stg[i];
      m_pending = 0;
    end
    check_cfg(tag);
  endtask

  initial begin
    bq_t f;
    int  len, r;
    logic [7:0] cmd;
    spi.spi_ss = 1'b1; spi.rx_stb = 1'b0; spi.rx_byte = 0; spi.rx_crc = 0; spi.tx_stb = 1'b0;
    model_reset();
    repeat (3) tick();
    rst = 1'b1;
    tick();

    check_cfg("rst");
    check("rst_tx", {24'd0, spi.tx_byte}, 0);
    check("rst_state", {30'd0, dbg_state}, 0);
    check("rst_pulses", {29'd0, frame_ok, frame_err, cfg_update}, 0);

    send_frame("wr_macr", mk_frame(8'h01, 8'h03, 32'h0000_0F00, 0), 0);
    check("macr_hold", {8'd0, cfg_maxacr}, 3839);
    apply_pulse("apply1");
    check("macr_new", {8'd0, cfg_maxacr}, 32'h0F00);

    send_frame("rd_id", mk_frame(8'h02, 8'h00, 32'h0, 0), 0);
    send_frame("rd_any", mk_frame(8'h02, 8'h03, 32'h0, 0), 0);

    send_frame("wr_badcrc", mk_frame(8'h01, 8'h02, 32'h9, 1), 0);
    check("badcrc_stwd", {28'd0, cfg_stwd}, 4);
    check("badcrc_cnt", {24'd0, crc_err_cnt}, 1);
    send_frame("after_crc", mk_frame(8'h02, 8'h07, 32'h0, 0), 0);

    f = mk_frame(8'h01, 8'h06, 32'h1234, 0); void'(f.pop_back());
    send_frame("len6", f, 0);
    f = mk_frame(8'h01, 8'h06, 32'h1234, 0); f.push_back(8'hAA); f.push_back(8'hBB);
    send_frame("len9", f, 0);
    send_frame("cmd5", mk_frame(8'h05, 8'h01, 32'h1, 0), 0);
    send_frame("wr07", mk_frame(8'h01, 8'h07, 32'h1, 0), 0);
    send_frame("rd08", mk_frame(8'h02, 8'h08, 32'h0, 0), 0);
    apply_pulse("apply_none");

    apply_ena = 1'b1;
    send_frame("wr_live", mk_frame(8'h01, 8'h01, 32'h1, 0), 1);
    check("live_upd_lat", upd_cyc - ok_cyc, 1);
    apply_ena = 1'b0;
    tick();

    f = {};
    send_frame("empty", f, 0);

    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 99);
      len = (r < 75) ? 7 : (r < 85) ? 6 : (r < 93) ? 9 : (r < 97) ? 2 : 0;
      r = $urandom_range(0, 19);
      cmd = (r < 9) ? 8'h01 : (r < 18) ? 8'h02 : 8'($urandom_range(0, 255));
      f = mk_frame(cmd, 8'($urandom_range(0, 9)), $urandom, $urandom_range(0, 9) == 0);
      while (f.size() > len) void'(f.pop_back());
      while (f.size() < len) f.push_back(8'($urandom_range(0, 255)));
      send_frame($sformatf("rnd%0d", t), f, 0);
      if ($urandom_range(0, 3) == 0) apply_pulse($sformatf("rnd_apply%0d", t));
    end

    spi.spi_ss = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      spi.rx_byte = 8'h01; spi.rx_stb = 1'b1; tick(); spi.rx_stb = 1'b0; tick();
    end
    rst = 1'b0;
    tick();
    spi.spi_ss = 1'b1;
    tick();
    model_reset();
    check_cfg("midrst");
    check("midrst_tx", {24'd0, spi.tx_byte}, 0);
    check("midrst_state", {30'd0, dbg_state}, 0);
    rst = 1'b1;
    tick();
    send_frame("post_rst", mk_frame(8'h01, 8'h04, 32'h7_1234, 0), 0);
    apply_pulse("post_apply");
    send_frame("final", mk_frame(8'h02, 8'h04, 32'h0, 0), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
